// File: rtl/alu_op_encoder.sv
// rtl/alu_op_encoder.sv - priority-encodes an 8-bit ALU function select into a 3-bit op and queues it
module alu_op_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [7:0]                 req_sel,
  output logic                       req_ready,
  output logic                       op_valid,
  output logic [2:0]                 op,
  input  logic                       op_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_sticky,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    enc_code;
  logic          push;
  logic          pop;
  logic          zero_req;

  // Scan downward so the lowest set bit is the last to assign and therefore wins.
  always_comb begin
    enc_code = 3'b000;
    for (int i = 7; i >= 0; i--) begin
      if (req_sel[i]) enc_code = 3'(i);
    end
  end

  assign req_ready  = (count < CW'(DEPTH));
  assign op_valid   = (count != '0);
  assign fifo_count = count;
  assign push       = req_valid && req_ready && (req_sel != 8'h00);
  assign zero_req   = req_valid && req_ready && (req_sel == 8'h00);
  assign pop        = op_valid && op_ready;

  // Head is read straight from storage; forced to zero while empty so stale entries never show.
  assign op = op_valid ? mem[rd_ptr] : 3'b000;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error outranks a clear in the same cycle.
      if (zero_req)     err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb/tb_alu_op_encoder.sv - randomized and directed checks of alu_op_encoder against a queue model
module tb_alu_op_encoder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_sel;
  logic       req_ready;
  logic       op_valid;
  logic [2:0] op;
  logic       op_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       err_sticky;
  logic       err_clr;

  int checks;
  int errors;

  int m_q[$];
  bit m_err;

  alu_op_encoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .op_valid   (op_valid),
    .op         (op),
    .op_ready   (op_ready),
    .fifo_count (fifo_count),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int enc(input logic [7:0] sel);
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op_valid"},   32'(op_valid),   32'(m_q.size() != 0));
    chk({tag, ".op"},         32'(op),         (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(m_q.size()));
    chk({tag, ".req_ready"},  32'(req_ready),  32'(m_q.size() < DEPTH));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
  endtask

  // Drives one cycle's inputs, advances the model with the same rules, checks after the edge.
  task automatic cycle(input string tag, input logic v, input logic [7:0] sel,
                       input logic rdy, input logic clr);
    bit do_push, do_pop, do_err;
    req_valid = v;
    req_sel   = sel;
    op_ready  = rdy;
    err_clr   = clr;
    do_pop  = (m_q.size() != 0) && rdy;
    do_push = v && (m_q.size() < DEPTH) && (sel != 8'h00);
    do_err  = v && (m_q.size() < DEPTH) && (sel == 8'h00);
    @(posedge clk);
    #1;
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(enc(sel));
    if (do_err)       m_err = 1'b1;
    else if (clr)     m_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] sel;
    checks = 0;
    errors = 0;
    m_err = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_sel = 8'h00;
    op_ready = 1'b0;
    err_clr = 1'b0;

    #3;
    check_all("reset");
    #9;
    rst_n = 1'b1;

    // single push then drain
    cycle("single_push", 1'b1, 8'h20, 1'b1, 1'b0);
    chk("single_push.code", 32'(op), 32'd5);
    cycle("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // priority
    cycle("prio_c8", 1'b1, 8'hC8, 1'b0, 1'b0);
    chk("prio_c8.code", 32'(op), 32'd3);
    cycle("prio_drain0", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("prio_80", 1'b1, 8'h80, 1'b0, 1'b0);
    chk("prio_80.code", 32'(op), 32'd7);
    cycle("prio_drain1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("prio_01", 1'b1, 8'h01, 1'b0, 1'b0);
    chk("prio_01.valid", 32'(op_valid), 32'd1);
    cycle("prio_drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // fill, held offer, drain
    cycle("fill0", 1'b1, 8'h02, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 8'h04, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 8'h10, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 8'h40, 1'b0, 1'b0);
    chk("fill.full_count", 32'(fifo_count), 32'd4);
    cycle("fill_held", 1'b1, 8'h80, 1'b0, 1'b0);
    cycle("drain_nobypass", 1'b1, 8'h80, 1'b1, 1'b0);
    chk("drain_nobypass.count", 32'(fifo_count), 32'd3);
    cycle("drain_accept", 1'b1, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.empty_op", 32'(op), 32'd0);

    // sustained push+pop across pointer wrap
    cycle("wrap_pre0", 1'b1, 8'h01, 1'b0, 1'b0);
    cycle("wrap_pre1", 1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      sel = 8'h01 << ((i + 2) % 8);
      cycle("wrap", 1'b1, sel, 1'b1, 1'b0);
      chk("wrap.count_const", 32'(fifo_count), 32'd2);
    end
    cycle("wrap_d0", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("wrap_d1", 1'b0, 8'h00, 1'b1, 1'b0);

    // sticky error
    cycle("err_set", 1'b1, 8'h00, 1'b0, 1'b0);
    chk("err_set.flag", 32'(err_sticky), 32'd1);
    cycle("err_clr_vs_set", 1'b1, 8'h00, 1'b0, 1'b1);
    cycle("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("err_clr.flag", 32'(err_sticky), 32'd0);

    // asynchronous reset mid-stream
    cycle("rst_q0", 1'b1, 8'h08, 1'b0, 1'b0);
    cycle("rst_q1", 1'b1, 8'h10, 1'b0, 1'b0);
    cycle("rst_q2", 1'b1, 8'h00, 1'b0, 1'b0);
    cycle("rst_q3", 1'b1, 8'h20, 1'b0, 1'b0);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_err = 1'b0;
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    cycle("post_rst_push", 1'b1, 8'h40, 1'b0, 1'b0);
    chk("post_rst_push.code", 32'(op), 32'd6);
    cycle("post_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      cycle("rand", 1'($urandom_range(0, 1)), sel, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_encoder.md
ALU_OP_ENCODER -- requirements
Module: alu_op_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, op queue depth in entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  upstream offers a select vector.
REQ-005 req_sel  input  8  select vector, bit i = function i (0 aop, 1 bop, 2 cop, 3 dop, 4 add, 5 sub, 6 awe, 7 fop).
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 op_valid  output  1  op holds a queued code for the ALU-side decoder.
REQ-008 op  output  3  encoded ALU op code.
REQ-009 op_ready  input  1  ALU side consumes op this cycle.
REQ-010 fifo_count  output  log2(DEPTH)+1  entries currently queued.
REQ-011 err_sticky  output  1  an all-zero select vector was offered since last clear.
REQ-012 err_clr  input  1  synchronous clear of err_sticky.

Function
REQ-013 Encoding: bit0->000, bit1->001, bit2->010, bit3->011, bit4->100, bit5->101, bit6->110, bit7->111.
REQ-014 Multiple bits set: lowest set index wins; other bits ignored, no error.
REQ-015 Push occurs when req_valid && req_ready && req_sel != 0; encoded code is written at queue tail.
REQ-016 req_valid && req_ready && req_sel == 0: no push, err_sticky set next edge, request consumed (dropped).
REQ-017 req_ready = (fifo_count < DEPTH); no same-cycle full bypass, even if a pop occurs that cycle.
REQ-018 Pop occurs when op_valid && op_ready; head advances one entry.
REQ-019 op_valid = (fifo_count != 0); op = head entry, registered, stable while op_valid && !op_ready.
REQ-020 op SHALL be 000 when queue empty.
REQ-021 Latency: push into empty queue at edge N -> op_valid=1 with that code after edge N (visible in cycle N+1); no combinational req->op path.
REQ-022 Simultaneous push and pop (queue non-empty, not full): fifo_count unchanged, order preserved.
REQ-023 Read/write pointers wrap modulo DEPTH; FIFO order strictly preserved across wrap.
REQ-024 fifo_count increments on push-only, decrements on pop-only, never exceeds DEPTH or underflows.
REQ-025 err_clr and a new zero-vector error in the same cycle: set wins (err_sticky=1).
REQ-026 op_ready while op_valid=0 has no effect.
REQ-027 Pure function of inputs and state; all outputs driven from registers or register-only logic.

Reset
REQ-028 rst_n=0 SHALL immediately force: fifo_count=0, op_valid=0, op=000, req_ready=1, err_sticky=0, pointers=0.
REQ-029 Reset mid-operation discards all queued entries; no partial pop or push completes on the reset edge.
REQ-030 After rst_n deasserts, first push accepted on first following rising edge.

Verification
REQ-031 Single push req_sel=0x20, op_ready=1 -> cycle after push op_valid=1, op=101; next cycle op_valid=0, fifo_count=0.
REQ-032 Priority: req_sel=0xC8 -> op=011; req_sel=0x80 -> op=111; req_sel=0x01 -> op=000 with op_valid=1.
REQ-033 Fill: op_ready=0, push 0x02,0x04,0x10,0x40 -> fifo_count=4, req_ready=0; 5th offer (0x80) held not pushed; then drain with op_ready=1 -> 001,010,100,110 in order, then 111 after its push.
REQ-034 Wrap/simultaneous: sustain push+pop every cycle for 3*DEPTH cycles with rotating one-hot vectors -> fifo_count constant, every code delivered once in order.
REQ-035 Error: push req_sel=0x00 -> no push, err_sticky=1; err_clr=1 with another 0x00 same cycle -> err_sticky stays 1; err_clr alone -> 0.
REQ-036 Reset mid-stream: 3 entries queued, rst_n=0 asynchronously between edges -> op_valid=0, fifo_count=0 immediately; after release, push 0x40 -> op=110.
